// File: rtl/ysyx_24100029_mdu_alu.sv
// Integer ALU plus radix-2 multiply/divide unit behind a valid/ready handshake.
// Single-cycle ops answer next cycle; mul/div iterate BW cycles on operand magnitudes.
module ysyx_24100029_mdu_alu #(
  parameter int BW  = 32,
  parameter int SHW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [4:0]    op,
  input  logic [BW-1:0] d1,
  input  logic [BW-1:0] d2,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] res,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_NEG = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4,  OP_XOR = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_NE  = 5'd8,  OP_SLL = 5'd9,  OP_SRL = 5'd10, OP_SRA = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

  state_e          state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [BW-1:0]   a_q, a_d, b_q, b_d, mcand_q, mcand_d, res_q, res_d;
  logic [2*BW-1:0] prod_q, prod_d;
  logic            neg_q, neg_d, ovf_q, ovf_d, flush_q;

  logic accept, in_multi, last;
  assign in_multi = (op[4:3] == 2'b10);
  assign accept   = in_valid && in_ready && !flush;
  assign last     = &cnt_q;

  // Single-cycle datapath, evaluated directly on the request operands.
  logic [BW-1:0]  sum, diff, alu_res;
  logic [SHW-1:0] shamt;
  logic           alu_ovf;
  assign sum   = d1 + d2;
  assign diff  = d1 - d2;
  assign shamt = d2[SHW-1:0];

  always_comb begin
    // NOTE: every output gets a default first so no branch leaves it unassigned (no latch).
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op)
      OP_ADD:  begin
        alu_res = sum;
        alu_ovf = (d1[BW-1] == d2[BW-1]) && (sum[BW-1] != d1[BW-1]);
      end
      OP_SUB:  begin
        alu_res = diff;
        alu_ovf = (d1[BW-1] != d2[BW-1]) && (diff[BW-1] != d1[BW-1]);
      end
      OP_NEG:  alu_res = ~d1 + {{(BW-1){1'b0}}, 1'b1};
      OP_AND:  alu_res = d1 & d2;
      OP_OR:   alu_res = d1 | d2;
      OP_XOR:  alu_res = d1 ^ d2;
      OP_SLT:  alu_res = {{(BW-1){1'b0}}, $signed(d1) < $signed(d2)};
      OP_SLTU: alu_res = {{(BW-1){1'b0}}, d1 < d2};
      OP_NE:   alu_res = {{(BW-1){1'b0}}, d1 != d2};
      OP_SLL:  alu_res = d1 << shamt;
      OP_SRL:  alu_res = d1 >> shamt;
      OP_SRA:  alu_res = $signed(d1) >>> shamt;
      default: ;
    endcase
  end

  // Magnitudes for the iterative ops; the sign is restored in the final cycle.
  logic          a_sgn, b_sgn;
  logic [BW-1:0] a_mag, b_mag;
  assign a_sgn = d1[BW-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
  assign b_sgn = d2[BW-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
  assign a_mag = a_sgn ? -d1 : d1;
  assign b_mag = b_sgn ? -d2 : d2;

  // One radix-2 step: shift-add for mul, restoring subtract for div ({rem, quo} in prod_q).
  logic [BW:0]     mul_sum, rem_sh, rem_diff;
  logic [BW-1:0]   rem_new, quo, rmd, fin;
  logic [2*BW-1:0] step, step_neg;
  assign mul_sum  = {1'b0, prod_q[2*BW-1:BW]} + (prod_q[0] ? {1'b0, mcand_q} : {(BW+1){1'b0}});
  assign rem_sh   = prod_q[2*BW-1:BW-1];
  assign rem_diff = rem_sh - {1'b0, mcand_q};
  assign rem_new  = rem_diff[BW] ? rem_sh[BW-1:0] : rem_diff[BW-1:0];
  assign step     = op_q[2] ? {rem_new, prod_q[BW-2:0], ~rem_diff[BW]}
                            : {mul_sum, prod_q[BW-1:1]};
  assign step_neg = neg_q ? -step : step;
  assign quo      = neg_q ? -step[BW-1:0] : step[BW-1:0];
  assign rmd      = neg_q ? -step[2*BW-1:BW] : step[2*BW-1:BW];

  always_comb begin
    fin = '0;
    case (op_q)
      OP_MUL:                       fin = step_neg[BW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin = step_neg[2*BW-1:BW];
      OP_DIV, OP_DIVU:              fin = (b_q == '0) ? '1 : quo;
      OP_REM, OP_REMU:              fin = (b_q == '0) ? a_q : rmd;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = in_multi ? CALC : DONE;
      CALC:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = accept ? (in_multi ? CALC : DONE) : IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  // flush_q blocks acceptance for the cycle right after a flush.
  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = !rst && !flush_q && (state_q == IDLE || (state_q == DONE && out_ready));
  end

  always_comb begin
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    neg_d   = neg_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    if (accept) begin
      op_d  = op;
      a_d   = d1;
      b_d   = d2;
      cnt_d = '0;
      if (in_multi) begin
        mcand_d = op[2] ? b_mag : a_mag;
        prod_d  = {{BW{1'b0}}, op[2] ? a_mag : b_mag};
        neg_d   = (op[2] && op[1]) ? a_sgn : (a_sgn ^ b_sgn);
      end else begin
        res_d = alu_res;
        ovf_d = alu_ovf;
      end
    end else if (state_q == CALC && !flush) begin
      prod_d = step;
      cnt_d  = cnt_q + 1'b1;
      if (last) begin
        res_d = fin;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      neg_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      flush_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of order.
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      neg_q   <= neg_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      flush_q <= flush;
    end
  end

  assign res      = res_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ysyx_24100029_mdu_alu.sv
// Directed bench for ysyx_24100029_mdu_alu (BW=32): ALU ops, mul/div results and
// latency, back-pressure, flush and mid-operation reset.
module tb_ysyx_24100029_mdu_alu;
  localparam int BW = 32;

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_NEG = 5'd2,  OP_AND = 5'd3;
  localparam logic [4:0] OP_OR  = 5'd4,  OP_XOR = 5'd5,  OP_SLT = 5'd6,  OP_SLTU = 5'd7;
  localparam logic [4:0] OP_NE  = 5'd8,  OP_SLL = 5'd9,  OP_SRL = 5'd10, OP_SRA = 5'd11;
  localparam logic [4:0] OP_MUL = 5'd16, OP_MULH = 5'd17, OP_MULHSU = 5'd18, OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV = 5'd20, OP_DIVU = 5'd21, OP_REM = 5'd22, OP_REMU = 5'd23;

  typedef struct packed {
    logic [4:0]    op;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic [BW-1:0] r;
    logic          v;
  } vec_t;

  localparam int N_ALU = 22;
  localparam vec_t ALU_VEC [N_ALU] = '{
    '{OP_ADD,  32'h0000_0005, 32'h0000_0003, 32'h0000_0008, 1'b0},
    '{OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1},
    '{OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1},
    '{OP_SUB,  32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0},
    '{OP_SUB,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
    '{OP_NEG,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0},
    '{OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0},
    '{OP_OR,   32'hF0F0_F0F0, 32'h0F00_0000, 32'hFFF0_F0F0, 1'b0},
    '{OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0},
    '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0},
    '{OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0},
    '{OP_NE,   32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0},
    '{OP_NE,   32'h0000_0005, 32'h0000_0006, 32'h0000_0001, 1'b0},
    '{OP_SLL,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b0},
    '{OP_SLL,  32'h0000_0003, 32'h0000_0021, 32'h0000_0006, 1'b0},
    '{OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0},
    '{OP_SRA,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 1'b0},
    '{OP_SRA,  32'h4000_0000, 32'h0000_0004, 32'h0400_0000, 1'b0},
    '{5'd12,   32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0},
    '{5'd24,   32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 1'b0},
    '{5'd31,   32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0}
  };

  localparam int N_MD = 19;
  localparam vec_t MD_VEC [N_MD] = '{
    '{OP_MUL,    32'h0000_0006, 32'h0000_0007, 32'h0000_002A, 1'b0},
    '{OP_MUL,    32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 1'b0},
    '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{OP_MULH,   32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0},
    '{OP_MULHSU, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
    '{OP_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, 1'b0},
    '{OP_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0},
    '{OP_REM,    32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0},
    '{OP_DIVU,   32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0},
    '{OP_REMU,   32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0},
    '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0},
    '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0},
    '{OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0},
    '{OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0},
    '{OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0},
    '{OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0},
    '{OP_DIVU,   32'hFFFF_FFFF, 32'h0000_0002, 32'h7FFF_FFFF, 1'b0},
    '{OP_REM,    32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 1'b0}
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b1;
  logic [4:0]    op = '0;
  logic [BW-1:0] d1 = '0;
  logic [BW-1:0] d2 = '0;
  logic          in_ready, out_valid, overflow;
  logic [BW-1:0] res;

  int checks = 0;
  int failures = 0;

  ysyx_24100029_mdu_alu #(.BW(BW), .SHW(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .d1        (d1),
    .d2        (d2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Present a request (called just after a falling edge) and return after the accepting edge.
  task automatic start_op(input logic [4:0] o, input logic [BW-1:0] a, input logic [BW-1:0] b);
    int g = 0;
    op = o; d1 = a; d2 = b; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 50) begin
      @(negedge clk); #1; g++;
    end
    if (g == 50) begin
      checks++; failures++;
      $display("FAIL accept_timeout in_ready stayed %b for op=%0d, required 1", in_ready, o);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; lat counts cycles from the accept cycle.
  task automatic wait_result(output logic [BW-1:0] r, output logic v, output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 60) begin
      @(negedge clk); lat++;
    end
    r = res; v = overflow;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({out_valid, in_ready, overflow, res} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got ov=%b ir=%b of=%b res=%h, required all 0",
               out_valid, in_ready, overflow, res);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ir=%b ov=%b, required ir=1 ov=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_overflow();
    logic [BW-1:0] r; logic v; int lat;
    start_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
    wait_result(r, v, lat);
    checks++;
    if (lat !== 1) begin failures++; $display("FAIL add_ovf_latency got %0d required 1", lat); end
    checks++;
    if (r !== 32'h8000_0000) begin failures++; $display("FAIL add_ovf_res got %h required 80000000", r); end
    checks++;
    if (v !== 1'b1) begin failures++; $display("FAIL add_ovf_flag got %b required 1", v); end
  endtask

  task automatic test_alu_ops();
    logic [BW-1:0] r; logic v; int lat;
    for (int i = 0; i < N_ALU; i++) begin
      start_op(ALU_VEC[i].op, ALU_VEC[i].a, ALU_VEC[i].b);
      wait_result(r, v, lat);
      checks++;
      if (r !== ALU_VEC[i].r) begin
        failures++;
        $display("FAIL alu_res[%0d] op=%0d got %h required %h", i, ALU_VEC[i].op, r, ALU_VEC[i].r);
      end
      checks++;
      if (v !== ALU_VEC[i].v) begin
        failures++;
        $display("FAIL alu_ovf[%0d] op=%0d got %b required %b", i, ALU_VEC[i].op, v, ALU_VEC[i].v);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL alu_latency[%0d] op=%0d got %0d required 1", i, ALU_VEC[i].op, lat);
      end
    end
  endtask

  task automatic test_mulhu_latency();
    logic [BW-1:0] r; logic v; int lat;
    start_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_result(r, v, lat);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL mulhu_latency got %0d required 33", lat); end
    checks++;
    if (r !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulhu_res got %h required fffffffe", r); end
  endtask

  task automatic test_mul_div();
    logic [BW-1:0] r; logic v; int lat;
    for (int i = 0; i < N_MD; i++) begin
      start_op(MD_VEC[i].op, MD_VEC[i].a, MD_VEC[i].b);
      wait_result(r, v, lat);
      checks++;
      if (r !== MD_VEC[i].r) begin
        failures++;
        $display("FAIL muldiv_res[%0d] op=%0d got %h required %h", i, MD_VEC[i].op, r, MD_VEC[i].r);
      end
      checks++;
      if (v !== 1'b0 || lat !== 33) begin
        failures++;
        $display("FAIL muldiv_timing[%0d] op=%0d got ovf=%b lat=%0d required ovf=0 lat=33",
                 i, MD_VEC[i].op, v, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] r; logic v; int lat;
    @(negedge clk);
    out_ready = 1'b0;
    start_op(OP_SRA, 32'h8000_0000, 32'h0000_0004);
    wait_result(r, v, lat);
    op = OP_ADD; d1 = 32'd2; d2 = 32'd3; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (res !== 32'hF800_0000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold[%0d] got res=%h ov=%b ir=%b required res=f8000000 ov=1 ir=0",
                 k, res, out_valid, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got %b required 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || res !== 32'd5) begin
      failures++;
      $display("FAIL b2b_result got ov=%b res=%h required ov=1 res=00000005", out_valid, res);
    end
  endtask

  task automatic test_flush();
    logic [BW-1:0] r; logic v; int lat; int seen = 0;
    start_op(OP_MUL, 32'd6, 32'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL flush_next got ov=%b ir=%b required ov=0 ir=0", out_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got %b required 1", in_ready); end
    repeat (40) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL flush_no_result got %0d valid cycles required 0", seen); end
    start_op(OP_ADD, 32'd10, 32'd20);
    wait_result(r, v, lat);
    checks++;
    if (r !== 32'd30 || lat !== 1) begin
      failures++;
      $display("FAIL flush_then_add got res=%h lat=%0d required res=0000001e lat=1", r, lat);
    end
  endtask

  task automatic test_rst_mid_calc();
    logic [BW-1:0] r; logic v; int lat; int seen = 0;
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, overflow, res} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs got ov=%b ir=%b of=%b res=%h required all 0",
               out_valid, in_ready, overflow, res);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b required 1", in_ready); end
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL rst_mid_no_result got %0d valid cycles required 0", seen); end
    start_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_result(r, v, lat);
    checks++;
    if (r !== 32'd1 || lat !== 1) begin
      failures++;
      $display("FAIL rst_mid_slt got res=%h lat=%0d required res=00000001 lat=1", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_alu_ops();
    test_mulhu_latency();
    test_mul_div();
    test_back_to_back();
    test_flush();
    test_rst_mid_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
